fetch_redirect_ctrl: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the pipelined core.

---
 rtl/core_pkg.sv | 21 ++
 rtl/pc_target_sel.sv | 45 ++++
 rtl/fetch_redirect_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-side types: PC source encoding and fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JALR = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_KILL
    } fetch_state_t;

endpackage

// File: rtl/pc_target_sel.sv
// Decodes the EX redirect select into a redirect strobe, target and misalign flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module pc_target_sel
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            redirect,
    output logic            misaligned,
    output logic [XLEN-1:0] target
);

    logic            sel_taken;
    logic [XLEN-1:0] sel_target;

    // Pick the target for the requested source; the reserved encoding behaves as sequential.
    always_comb begin
        sel_taken  = 1'b0;
        sel_target = branch_target;
        case (pc_src_t'(pc_src))
            PC_BR: begin
                sel_taken  = 1'b1;
                sel_target = branch_target;
            end
            PC_JALR: begin
                sel_taken  = 1'b1;
                sel_target = {jalr_target[XLEN-1:1], 1'b0};
            end
            default: begin
                sel_taken  = 1'b0;
                sel_target = branch_target;
            end
        endcase
    end

    // A word-misaligned target is reported instead of being followed.
    assign misaligned = sel_taken && (sel_target[1:0] != 2'b00);
    assign redirect   = sel_taken && (sel_target[1:0] == 2'b00);
    assign target     = sel_target;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Owns the PC, issues one imem request at a time and hands fetched words to decode.
// Latency: 1 request cycle + imem latency + 1 hold cycle per word; redirect target on imem_req_addr at t+1 (or after a stale response drains).
// Backpressure: imem_req_ready stalls the request with address held; if_ready low holds the word in if_* indefinitely.
module fetch_redirect_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            if_ready,
    output logic            flush,
    output logic            misalign_exc
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;

    logic            redirect;
    logic            misaligned;
    logic [XLEN-1:0] target;
    logic            req_hs;

    pc_target_sel #(
        .XLEN(XLEN)
    ) u_pc_target_sel (
        .pc_src        (PCSrc),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .redirect      (redirect),
        .misaligned    (misaligned),
        .target        (target)
    );

    assign req_hs = (state_q == S_REQ) && imem_req_ready;

    // Next-state and register updates; a redirect overrides every normal transition.
    // A misaligned target is not a redirect, so the FSM simply keeps sequencing.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d    = target;
                    // A request accepted this cycle is now stale and must be drained.
                    state_d = req_hs ? S_KILL : S_REQ;
                end else if (req_hs) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    // A response landing this cycle is dropped; otherwise wait it out.
                    state_d = imem_rsp_valid ? S_REQ : S_KILL;
                end else if (imem_rsp_valid) begin
                    if_pc_d    = req_pc_q;
                    if_instr_d = imem_rsp_data;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // Any word handed off alongside a redirect is killed by flush downstream.
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (if_ready) begin
                    state_d = S_REQ;
                end
            end
            S_KILL: begin
                if (redirect) begin
                    pc_d = target;
                end else if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State, PC and fetched-word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Outputs are forced low while reset is held.
    assign imem_req_valid = !reset && (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = !reset && (state_q == S_HOLD);
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign flush          = !reset && redirect;
    assign misalign_exc   = !reset && misaligned;

    // imem may only answer while a request is outstanding.
    rsp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_KILL)
    );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with a small fixed-latency imem model.
// Latency: imem response arrives lat cycles after each accepted request.
// Backpressure: imem always ready; if_ready driven per test.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PCSrc;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic        misalign_exc;

    // second instance, high reset PC, shares all inputs
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;
    logic        w_flush;
    logic        w_misalign;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;
    int cnt   = 0;
    logic [31:0] rsp_addr = '0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .if_ready(if_ready), .flush(flush),
        .misalign_exc(misalign_exc)
    );

    fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .PCSrc(PCSrc),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(w_if_valid), .if_pc(w_if_pc),
        .if_instr(w_if_instr), .if_ready(if_ready), .flush(w_flush),
        .misalign_exc(w_misalign)
    );

    // imem model: answers each accepted request after lat cycles with ~addr.
    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0;
        end else if (imem_req_valid && imem_req_ready) begin
            cnt      <= lat;
            rsp_addr <= imem_req_addr;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end
    assign imem_rsp_valid = (cnt == 1);
    assign imem_rsp_data  = ~rsp_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        PCSrc          = 2'b00;
        branch_target  = '0;
        jalr_target    = '0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        step();
        step();
        // reset state
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_flush", 32'(flush), 32'd0);
        reset = 1'b0;
        #1;

        // sequential fetch, one word per 3 cycles
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("seq%0d_req_valid", k), 32'(imem_req_valid), 32'd1);
            chk($sformatf("seq%0d_req_addr", k), imem_req_addr, 32'(4 * k));
            if (k == 0) chk("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
            if (k == 1) chk("wrap_addr1", w_req_addr, 32'h0000_0000);
            step();
            chk($sformatf("seq%0d_wait_no_req", k), 32'(imem_req_valid), 32'd0);
            step();
            chk($sformatf("seq%0d_if_valid", k), 32'(if_valid), 32'd1);
            chk($sformatf("seq%0d_if_pc", k), if_pc, 32'(4 * k));
            chk($sformatf("seq%0d_if_instr", k), if_instr, ~32'(4 * k));
            step();
        end

        // branch redirect while holding the word from 0xC
        step();
        step();
        chk("br_hold_pc", if_pc, 32'h0000_000C);
        PCSrc         = 2'b01;
        branch_target = 32'h0000_0100;
        #1;
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_no_misalign", 32'(misalign_exc), 32'd0);
        step();
        PCSrc = 2'b00;
        #1;
        chk("br_flush_pulse", 32'(flush), 32'd0);
        chk("br_if_valid_clr", 32'(if_valid), 32'd0);
        chk("br_req_addr", imem_req_addr, 32'h0000_0100);
        step();
        step();
        chk("br_new_if_valid", 32'(if_valid), 32'd1);
        chk("br_new_if_pc", if_pc, 32'h0000_0100);
        step();

        // jalr redirect while waiting on a 3-cycle response
        lat = 3;
        chk("jalr_pre_addr", imem_req_addr, 32'h0000_0104);
        step();
        PCSrc       = 2'b10;
        jalr_target = 32'h0000_0201;
        #1;
        chk("jalr_flush", 32'(flush), 32'd1);
        step();
        PCSrc = 2'b00;
        #1;
        chk("kill_no_req", 32'(imem_req_valid), 32'd0);
        chk("kill_flush_pulse", 32'(flush), 32'd0);
        step();
        chk("kill_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        chk("kill_no_if_valid", 32'(if_valid), 32'd0);
        chk("kill_no_req2", 32'(imem_req_valid), 32'd0);
        step();
        lat = 1;
        chk("jalr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("jalr_req_addr", imem_req_addr, 32'h0000_0200);
        step();
        step();
        chk("jalr_if_pc", if_pc, 32'h0000_0200);
        chk("jalr_if_instr", if_instr, 32'hFFFF_FDFF);
        step();

        // misaligned branch target while holding with decode stalled
        step();
        step();
        if_ready      = 1'b0;
        PCSrc         = 2'b01;
        branch_target = 32'h0000_0102;
        #1;
        chk("mis_exc", 32'(misalign_exc), 32'd1);
        chk("mis_no_flush", 32'(flush), 32'd0);
        step();
        PCSrc = 2'b00;
        #1;
        chk("mis_exc_pulse", 32'(misalign_exc), 32'd0);
        chk("mis_still_held", 32'(if_valid), 32'd1);
        chk("mis_if_pc", if_pc, 32'h0000_0204);
        if_ready = 1'b1;
        step();
        chk("mis_seq_addr", imem_req_addr, 32'h0000_0208);

        // stall in hold for 5 cycles, then reset mid-hold
        step();
        step();
        if_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_if_valid", c), 32'(if_valid), 32'd1);
            chk($sformatf("stall%0d_if_pc", c), if_pc, 32'h0000_0208);
            chk($sformatf("stall%0d_if_instr", c), if_instr, 32'hFFFF_FDF7);
            chk($sformatf("stall%0d_no_req", c), 32'(imem_req_valid), 32'd0);
            step();
        end
        reset = 1'b1;
        step();
        chk("mrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mrst_if_valid", 32'(if_valid), 32'd0);
        chk("mrst_if_pc", if_pc, 32'h0);
        chk("mrst_if_instr", if_instr, 32'h0);
        reset    = 1'b0;
        if_ready = 1'b1;
        #1;
        chk("mrst_req_valid_after", 32'(imem_req_valid), 32'd1);
        chk("mrst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("mrst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk("mrst_if_pc_after", if_pc, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
